inst_queue: RTL and testbench

Circular instruction buffer between the fetch stage and decode/dispatch. Captures one instruction word plus its PC per cycle from the instruction-memory response and presents up to SS oldest entries per cycle, in program order, to decode. Raises `stall_inst` to the fetch stage when it cannot accept a word, and discards all contents on a branch redirect.

---
 rtl/rv32i_types.sv | 11 +
 rtl/inst_queue.sv | 94 +++++++++
 tb/tb_inst_queue.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/rv32i_types.sv
// rv32i_types: types shared across the RV32I pipeline front end.
//   fetch_pkt_t - one fetched instruction word together with its PC.
//                 Decode imports this when building instruction_info_reg_t.
package rv32i_types;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } fetch_pkt_t;

endpackage

// File: rtl/inst_queue.sv
// inst_queue: circular instruction buffer between fetch and decode/dispatch.
// Accepts one {inst, pc} per cycle from the imem response and presents up to SS
// oldest entries per cycle, lane 0 oldest. A redirect (flush) discards everything.
//
// Ports
//   clk         clock, rising edge
//   rst         asynchronous active-low reset
//   enq_valid   imem response word present this cycle
//   enq_inst    instruction word
//   enq_pc      PC of the word
//   flush       redirect: drop all entries and this cycle's word
//   deq_ready   decode consumes every valid lane this cycle
//   deq_valid   per-lane valid, lane i valid when occupancy > i
//   deq_pkt     per-lane {inst, pc}
//   stall_inst  queue full; fetch must hold its PC
//   count       current occupancy
module inst_queue
  import rv32i_types::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned SS    = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enq_valid,
  input  logic [31:0]              enq_inst,
  input  logic [31:0]              enq_pc,
  input  logic                     flush,
  input  logic                     deq_ready,
  output logic [SS-1:0]            deq_valid,
  output fetch_pkt_t               deq_pkt [SS],
  output logic                     stall_inst,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  fetch_pkt_t      mem [DEPTH];
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   pop_n;
  logic            enq_fire;

  assign count      = count_q;
  // Full check uses the registered count only: a same-cycle pop frees nothing.
  assign stall_inst = (count_q == CW'(DEPTH));

  always_comb begin
    enq_fire = enq_valid & ~stall_inst & ~flush;
    pop_n    = '0;
    if (deq_ready) begin
      pop_n = (count_q > CW'(SS)) ? CW'(SS) : count_q;
    end
    // pop_n never exceeds SS <= DEPTH/2, so truncation to pointer width is exact.
    rd_ptr_d = rd_ptr_q + pop_n[PW-1:0];
    wr_ptr_d = wr_ptr_q + {{(PW-1){1'b0}}, enq_fire};
    count_d  = count_q + {{(CW-1){1'b0}}, enq_fire} - pop_n;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (enq_fire) begin
      mem[wr_ptr_q] <= '{inst: enq_inst, pc: enq_pc};
    end
  end

  // Lane index wraps by power-of-two truncation.
  always_comb begin
    for (int unsigned i = 0; i < SS; i++) begin
      deq_valid[i] = (count_q > CW'(i));
      deq_pkt[i]   = mem[PW'(rd_ptr_q + PW'(i))];
    end
  end

endmodule

// File: tb/tb_inst_queue.sv
module tb_inst_queue;
  import rv32i_types::*;

  logic             clk;
  logic             rst;
  logic             enq_valid;
  logic [31:0]      enq_inst;
  logic [31:0]      enq_pc;
  logic             flush;
  logic             deq_ready;
  logic [1:0]       deq_valid;
  fetch_pkt_t       deq_pkt [2];
  logic             stall_inst;
  logic [4:0]       count;

  int n_total;
  int n_bad;

  inst_queue #(.DEPTH(16), .SS(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .enq_valid  (enq_valid),
    .enq_inst   (enq_inst),
    .enq_pc     (enq_pc),
    .flush      (flush),
    .deq_ready  (deq_ready),
    .deq_valid  (deq_valid),
    .deq_pkt    (deq_pkt),
    .stall_inst (stall_inst),
    .count      (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%08h want=0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_enq(input logic v, input logic [31:0] pc);
    enq_valid = v;
    enq_pc    = pc;
    enq_inst  = pc ^ 32'hA5A5_0000;
  endtask

  task automatic push(input logic [31:0] pc);
    set_enq(1'b1, pc);
    cycle();
    set_enq(1'b0, 32'h0);
  endtask

  task automatic do_flush();
    flush = 1'b1;
    cycle();
    flush = 1'b0;
  endtask

  initial begin
    n_total   = 0;
    n_bad     = 0;
    rst       = 1'b0;
    flush     = 1'b0;
    deq_ready = 1'b0;
    set_enq(1'b0, 32'h0);
    repeat (3) cycle();
    check("reset_count", 32'(count), 32'd0);
    check("reset_valid", 32'(deq_valid), 32'd0);
    check("reset_stall", 32'(stall_inst), 32'd0);
    rst = 1'b1;
    cycle();

    // Fill to full with deq_ready low.
    for (int k = 0; k < 16; k++) push(32'h6000_0000 + 32'(4 * k));
    check("fill_count", 32'(count), 32'd16);
    check("fill_stall", 32'(stall_inst), 32'd1);
    check("fill_lane0_pc", deq_pkt[0].pc, 32'h6000_0000);
    check("fill_lane0_inst", deq_pkt[0].inst, 32'h6000_0000 ^ 32'hA5A5_0000);
    check("fill_lane1_pc", deq_pkt[1].pc, 32'h6000_0004);
    push(32'h6000_0040);
    check("drop17_count", 32'(count), 32'd16);

    // Enqueue + pop while full: word dropped, two popped.
    set_enq(1'b1, 32'h6000_0040);
    deq_ready = 1'b1;
    cycle();
    check("fullpop_count", 32'(count), 32'd14);
    check("fullpop_stall", 32'(stall_inst), 32'd0);
    check("fullpop_lane0", deq_pkt[0].pc, 32'h6000_0008);
    cycle();
    check("retry_count", 32'(count), 32'd13);
    check("retry_lane0", deq_pkt[0].pc, 32'h6000_0010);
    set_enq(1'b0, 32'h0);
    deq_ready = 1'b0;
    do_flush();
    check("flush1_count", 32'(count), 32'd0);

    // Dual dequeue order from 5 entries: pops 2, 2, 1.
    for (int k = 0; k < 5; k++) push(32'h6000_0000 + 32'(4 * k));
    check("dual_lane0_a", deq_pkt[0].pc, 32'h6000_0000);
    check("dual_valid_a", 32'(deq_valid), 32'd3);
    deq_ready = 1'b1;
    cycle();
    check("dual_count_b", 32'(count), 32'd3);
    check("dual_lane0_b", deq_pkt[0].pc, 32'h6000_0008);
    check("dual_lane1_b", deq_pkt[1].pc, 32'h6000_000C);
    cycle();
    check("dual_count_c", 32'(count), 32'd1);
    check("dual_lane0_c", deq_pkt[0].pc, 32'h6000_0010);
    check("dual_valid1_c", 32'(deq_valid[1]), 32'd0);
    cycle();
    check("dual_count_d", 32'(count), 32'd0);
    check("dual_valid_d", 32'(deq_valid), 32'd0);
    // deq_ready while empty is harmless.
    cycle();
    check("empty_pop_count", 32'(count), 32'd0);
    deq_ready = 1'b0;

    // Wrap-around from a clean start.
    do_flush();
    for (int k = 0; k < 14; k++) push(32'h7000_0000 + 32'(4 * k));
    deq_ready = 1'b1;
    repeat (7) cycle();
    deq_ready = 1'b0;
    check("wrap_empty", 32'(count), 32'd0);
    push(32'h7000_0038);
    push(32'h7000_003C);
    check("wrap_wrptr0", 32'(dut.wr_ptr_q), 32'd0);
    push(32'h7000_0040);
    push(32'h7000_0044);
    check("wrap_wrptr2", 32'(dut.wr_ptr_q), 32'd2);
    check("wrap_count", 32'(count), 32'd4);
    check("wrap_lane0", deq_pkt[0].pc, 32'h7000_0038);
    check("wrap_lane1", deq_pkt[1].pc, 32'h7000_003C);
    deq_ready = 1'b1;
    cycle();
    deq_ready = 1'b0;
    check("wrap_lane0_b", deq_pkt[0].pc, 32'h7000_0040);
    check("wrap_lane1_b", deq_pkt[1].pc, 32'h7000_0044);

    // Flush with a same-cycle enqueue.
    do_flush();
    for (int k = 0; k < 7; k++) push(32'h8000_0000 + 32'(4 * k));
    check("pre_flush_count", 32'(count), 32'd7);
    set_enq(1'b1, 32'h6000_0100);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    set_enq(1'b0, 32'h0);
    check("flushenq_count", 32'(count), 32'd0);
    check("flushenq_valid", 32'(deq_valid), 32'd0);
    push(32'h6000_0200);
    check("postflush_lane0", deq_pkt[0].pc, 32'h6000_0200);
    check("postflush_valid", 32'(deq_valid), 32'd1);

    // Async reset mid-operation with 9 entries.
    for (int k = 0; k < 8; k++) push(32'h8800_0000 + 32'(4 * k));
    check("prereset_count", 32'(count), 32'd9);
    #3;
    rst = 1'b0;
    #1;
    check("async_valid", 32'(deq_valid), 32'd0);
    check("async_stall", 32'(stall_inst), 32'd0);
    check("async_count", 32'(count), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    cycle();
    push(32'h9000_0000);
    check("rst_land_idx0", dut.mem[0].pc, 32'h9000_0000);
    check("rst_lane0", deq_pkt[0].pc, 32'h9000_0000);
    check("rst_count", 32'(count), 32'd1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  // Hard bound so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout: got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule
